free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameters: PHYS_REGS, default 64, number of physical registers; PHYS_WIDTH, default 6, physical register ID width; ARCH_REGS, default 32, number of architectural registers.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 FREEZE  input  1  pipeline stall; when high, no state changes except RESET.
REQ-005 allocReq_IN  input  1  rename requests one physical register this cycle.
REQ-006 allocValid_OUT  output  1  a free register is offered on allocId_OUT.
REQ-007 allocId_OUT  output  PHYS_WIDTH  offered free register ID.
REQ-008 freeReq_IN  input  1  commit returns a register to the pool.
REQ-009 freeId_IN  input  PHYS_WIDTH  ID being returned.
REQ-010 recover_IN  input  1  flush; rebuild the pool from the retirement RAT.
REQ-011 retRat_IN  input  ARCH_REGS*PHYS_WIDTH  retirement RAT; entry 0 in the MSBs; entry i at bits [W-1-6i : W-6-6i].
REQ-012 busy_OUT  output  1  rebuild in progress.
REQ-013 freeCount_OUT  output  PHYS_WIDTH+1  number of free registers.

Function
REQ-014 Storage SHALL be a PHYS_REGS-bit free vector; bit = 1 means free.
REQ-015 FSM SHALL have two states: IDLE and REBUILD.
REQ-016 In IDLE, allocId_OUT SHALL be combinationally the lowest-index free bit; allocValid_OUT = (IDLE && any bit free).
REQ-017 Effective alloc = allocReq_IN && allocValid_OUT && IDLE && !FREEZE; it clears the bit of allocId_OUT at the next edge.
REQ-018 An allocReq_IN while allocValid_OUT = 0 SHALL be ignored, with no state change.
REQ-019 Effective free = freeReq_IN && IDLE && !FREEZE && bit[freeId_IN] == 0; it sets the bit at the next edge.
REQ-020 A free of an already-free ID (double free) SHALL be ignored.
REQ-021 If an alloc and a free target the same ID in one cycle, the alloc SHALL win and the bit ends cleared.
REQ-022 freeCount_OUT SHALL change by +1 per effective free and -1 per effective alloc (net 0 when both occur); it SHALL always equal the popcount of the vector.
REQ-023 recover_IN && !FREEZE in any state SHALL, at the next edge:
- capture retRat_IN into an internal snapshot;
- set all vector bits to 1 and freeCount to PHYS_REGS;
- set the rebuild index to 0 and enter REBUILD.
Alloc and free requests in that cycle SHALL be dropped.
REQ-024 In REBUILD, each non-frozen cycle SHALL clear bit[snapshot entry index], decrementing the count only if the bit was set (duplicate mappings are tolerated), then increment the index.
REQ-025 The transition REBUILD -> IDLE SHALL occur on the edge that processes index ARCH_REGS-1, so REBUILD lasts exactly ARCH_REGS non-frozen cycles.
REQ-026 In REBUILD: busy_OUT = 1, allocValid_OUT = 0, freeReq_IN ignored; recover_IN restarts the rebuild from index 0 with a new snapshot.
REQ-027 FREEZE high SHALL hold the vector, count, FSM state, index and snapshot unchanged; recover_IN is not latched while frozen (the producer holds it asserted).
REQ-028 Alloc-to-reuse latency: a register freed at edge N SHALL be allocatable from cycle N+1.

Reset
REQ-029 RESET SHALL override all other inputs, including FREEZE, in IDLE or REBUILD.
REQ-030 Reset state:
- FSM IDLE, index 0, snapshot 0;
- bits 0..ARCH_REGS-1 cleared (identity-mapped); bits ARCH_REGS..PHYS_REGS-1 set;
- freeCount_OUT = 32, busy_OUT = 0, allocValid_OUT = 1, allocId_OUT = 32.

Verification
REQ-031 Reset, then allocReq_IN high for 33 cycles -> IDs 32..63 granted in order; then allocValid_OUT = 0 and count = 0; the 33rd request causes no change.
REQ-032 From empty: free ID 40 -> next cycle allocId_OUT = 40, count = 1; free 40 again -> count stays 1.
REQ-033 Simultaneous alloc (ID 33) and free (ID 50) when 33 is lowest free -> bit 33 cleared, bit 50 set, count unchanged.
REQ-034 recover_IN with entry i = i+32 -> busy_OUT = 1 and allocValid_OUT = 0 for 32 cycles; then free bits 0..31, allocId_OUT = 0, count = 32.
REQ-035 Second recover_IN (identity map) at REBUILD cycle 10 -> rebuild restarts, 32 more busy cycles, final allocId_OUT = 32, count = 32.
REQ-036 RESET at REBUILD cycle 5, with FREEZE high -> next cycle reset state per REQ-030.

Source files
------------

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module   : free_list
//  Purpose  : Physical-register free list for a register-renaming pipeline.
//             Keeps a PHYS_REGS-bit vector (1 = free), offers the lowest free
//             ID each cycle, accepts registers returned at commit, and on a
//             flush rebuilds the pool from a snapshot of the retirement RAT,
//             one architectural entry per cycle.
//  Ports    : CLK            - clock, all state on the rising edge
//             RESET          - synchronous active-high reset (beats FREEZE)
//             FREEZE         - stall, holds every piece of state
//             allocReq_IN    - rename wants one register this cycle
//             allocValid_OUT - a free register is offered on allocId_OUT
//             allocId_OUT    - lowest-index free register
//             freeReq_IN     - commit returns freeId_IN to the pool
//             freeId_IN      - register being returned
//             recover_IN     - flush, rebuild the pool from retRat_IN
//             retRat_IN      - retirement RAT, entry 0 in the MSBs
//             busy_OUT       - rebuild in progress
//             freeCount_OUT  - number of free registers (popcount of vector)
//  Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int PHYS_REGS  = 64,
  parameter int PHYS_WIDTH = 6,
  parameter int ARCH_REGS  = 32
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            FREEZE,
  input  logic                            allocReq_IN,
  output logic                            allocValid_OUT,
  output logic [PHYS_WIDTH-1:0]           allocId_OUT,
  input  logic                            freeReq_IN,
  input  logic [PHYS_WIDTH-1:0]           freeId_IN,
  input  logic                            recover_IN,
  input  logic [ARCH_REGS*PHYS_WIDTH-1:0] retRat_IN,
  output logic                            busy_OUT,
  output logic [PHYS_WIDTH:0]             freeCount_OUT
);

  localparam int C_CW    = PHYS_WIDTH + 1;
  localparam int C_IDX_W = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;
  localparam int C_RAT_W = ARCH_REGS * PHYS_WIDTH;

  // Out of reset the architectural registers are identity-mapped onto
  // physical 0..ARCH_REGS-1, so only the upper registers start out free.
  function automatic logic [PHYS_REGS-1:0] f_reset_free();
    logic [PHYS_REGS-1:0] v;
    for (int i = 0; i < PHYS_REGS; i++) begin
      v[i] = (i >= ARCH_REGS);
    end
    return v;
  endfunction

  localparam logic [PHYS_REGS-1:0] C_RESET_FREE  = f_reset_free();
  localparam logic [C_CW-1:0]      C_RESET_COUNT = C_CW'(PHYS_REGS - ARCH_REGS);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_REBUILD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PHYS_REGS-1:0]   free_q,  free_d;
  logic [C_CW-1:0]        count_q, count_d;
  logic [C_IDX_W-1:0]     idx_q,   idx_d;
  logic [C_RAT_W-1:0]     snap_q,  snap_d;

  logic [PHYS_WIDTH-1:0]  w_alloc_id;
  logic [PHYS_REGS-1:0]   w_alloc_mask;
  logic [PHYS_REGS-1:0]   w_free_mask;
  logic [PHYS_WIDTH-1:0]  w_rb_entry;
  logic [PHYS_REGS-1:0]   w_rb_mask;
  logic                   w_idle;
  logic                   w_any_free;
  logic                   w_alloc_eff;
  logic                   w_free_eff;
  logic                   w_rb_hit;

  assign w_idle     = (state_q == S_IDLE);
  assign w_any_free = |free_q;

  // Lowest set bit: the loop runs high-to-low so the lowest index is the
  // last one written. The mask isolates the same bit arithmetically.
  always_comb begin
    w_alloc_id = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        w_alloc_id = PHYS_WIDTH'(i);
      end
    end
  end

  assign w_alloc_mask = free_q & (~free_q + PHYS_REGS'(1));

  // Decoded masks; an ID outside 0..PHYS_REGS-1 decodes to all-zero and
  // therefore has no effect.
  always_comb begin
    w_free_mask = '0;
    w_rb_mask   = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      w_free_mask[i] = (freeId_IN  == PHYS_WIDTH'(i));
      w_rb_mask[i]   = (w_rb_entry == PHYS_WIDTH'(i));
    end
  end

  // Snapshot entry e lives at the e-th field counted from the MSB end.
  always_comb begin
    w_rb_entry = '0;
    for (int e = 0; e < ARCH_REGS; e++) begin
      if (idx_q == C_IDX_W'(e)) begin
        w_rb_entry = snap_q[(ARCH_REGS - 1 - e) * PHYS_WIDTH +: PHYS_WIDTH];
      end
    end
  end

  assign w_alloc_eff = allocReq_IN && allocValid_OUT && w_idle && !FREEZE && !recover_IN;
  // Only a register that is currently allocated may be returned; a double
  // free finds its bit already set and is dropped.
  assign w_free_eff  = freeReq_IN && w_idle && !FREEZE && !recover_IN &&
                       (|(w_free_mask & ~free_q));
  // Duplicate RAT mappings clear an already-cleared bit; count only real
  // transitions so the count stays equal to the popcount.
  assign w_rb_hit    = |(w_rb_mask & free_q);

  always_comb begin
    state_d = state_q;
    free_d  = free_q;
    count_d = count_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (!FREEZE) begin
      if (recover_IN) begin
        snap_d  = retRat_IN;
        free_d  = '1;
        count_d = C_CW'(PHYS_REGS);
        idx_d   = '0;
        state_d = S_REBUILD;
      end else if (state_q == S_IDLE) begin
        // Free is applied first so that, should both ever hit one bit,
        // the alloc wins and the bit ends cleared.
        if (w_free_eff) begin
          free_d = free_d | w_free_mask;
        end
        if (w_alloc_eff) begin
          free_d = free_d & ~w_alloc_mask;
        end
        count_d = count_q + C_CW'(w_free_eff) - C_CW'(w_alloc_eff);
      end else begin
        free_d = free_q & ~w_rb_mask;
        if (w_rb_hit) begin
          count_d = count_q - C_CW'(1);
        end
        if (idx_q == C_IDX_W'(ARCH_REGS - 1)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + C_IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      free_q  <= C_RESET_FREE;
      count_q <= C_RESET_COUNT;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign allocValid_OUT = w_idle && w_any_free;
  assign allocId_OUT    = w_alloc_id;
  assign busy_OUT       = (state_q == S_REBUILD);
  assign freeCount_OUT  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_free_list
//  Purpose  : Directed self-checking bench for free_list with hand-computed
//             expected values, one task per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

  localparam int PHYS_REGS  = 64;
  localparam int PHYS_WIDTH = 6;
  localparam int ARCH_REGS  = 32;

  logic                            CLK;
  logic                            RESET;
  logic                            FREEZE;
  logic                            allocReq_IN;
  logic                            allocValid_OUT;
  logic [PHYS_WIDTH-1:0]           allocId_OUT;
  logic                            freeReq_IN;
  logic [PHYS_WIDTH-1:0]           freeId_IN;
  logic                            recover_IN;
  logic [ARCH_REGS*PHYS_WIDTH-1:0] retRat_IN;
  logic                            busy_OUT;
  logic [PHYS_WIDTH:0]             freeCount_OUT;

  int tests;
  int fails;

  free_list #(
    .PHYS_REGS (PHYS_REGS),
    .PHYS_WIDTH(PHYS_WIDTH),
    .ARCH_REGS (ARCH_REGS)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .FREEZE        (FREEZE),
    .allocReq_IN   (allocReq_IN),
    .allocValid_OUT(allocValid_OUT),
    .allocId_OUT   (allocId_OUT),
    .freeReq_IN    (freeReq_IN),
    .freeId_IN     (freeId_IN),
    .recover_IN    (recover_IN),
    .retRat_IN     (retRat_IN),
    .busy_OUT      (busy_OUT),
    .freeCount_OUT (freeCount_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RAT with entry i = i + offset (offset 0 gives the identity map).
  task automatic set_rat_offset(input int offset);
    for (int i = 0; i < ARCH_REGS; i++) begin
      retRat_IN[(ARCH_REGS - 1 - i) * PHYS_WIDTH +: PHYS_WIDTH] = PHYS_WIDTH'(i + offset);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tests++; if (freeCount_OUT !== 7'd32) begin fails++; $display("FAIL reset_count: got %0d want 32", freeCount_OUT); end
    tests++; if (busy_OUT !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy_OUT); end
    tests++; if (allocValid_OUT !== 1'b1) begin fails++; $display("FAIL reset_valid: got %0b want 1", allocValid_OUT); end
    tests++; if (allocId_OUT !== 6'd32) begin fails++; $display("FAIL reset_id: got %0d want 32", allocId_OUT); end
  endtask

  task automatic test_alloc_all();
    allocReq_IN = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (allocValid_OUT !== 1'b1 || allocId_OUT !== 6'(32 + k)) begin
        fails++;
        $display("FAIL alloc_seq[%0d]: got valid=%0b id=%0d want valid=1 id=%0d", k, allocValid_OUT, allocId_OUT, 32 + k);
      end
      tick();
    end
    tests++; if (allocValid_OUT !== 1'b0) begin fails++; $display("FAIL empty_valid: got %0b want 0", allocValid_OUT); end
    tests++; if (freeCount_OUT !== 7'd0) begin fails++; $display("FAIL empty_count: got %0d want 0", freeCount_OUT); end
    tick();
    allocReq_IN = 1'b0;
    tests++; if (freeCount_OUT !== 7'd0 || allocValid_OUT !== 1'b0) begin fails++; $display("FAIL alloc_when_empty: got count=%0d valid=%0b want 0/0", freeCount_OUT, allocValid_OUT); end
  endtask

  task automatic test_free_reuse();
    freeReq_IN = 1'b1; freeId_IN = 6'd40;
    tick();
    freeReq_IN = 1'b0;
    tests++; if (allocValid_OUT !== 1'b1 || allocId_OUT !== 6'd40) begin fails++; $display("FAIL reuse_id: got valid=%0b id=%0d want 1/40", allocValid_OUT, allocId_OUT); end
    tests++; if (freeCount_OUT !== 7'd1) begin fails++; $display("FAIL reuse_count: got %0d want 1", freeCount_OUT); end
    freeReq_IN = 1'b1; freeId_IN = 6'd40;
    tick();
    freeReq_IN = 1'b0;
    tests++; if (freeCount_OUT !== 7'd1) begin fails++; $display("FAIL double_free_count: got %0d want 1", freeCount_OUT); end
    // Alloc and free of the same ID in one cycle: alloc wins.
    allocReq_IN = 1'b1; freeReq_IN = 1'b1; freeId_IN = 6'd40;
    tick();
    allocReq_IN = 1'b0; freeReq_IN = 1'b0;
    tests++; if (freeCount_OUT !== 7'd0 || allocValid_OUT !== 1'b0) begin fails++; $display("FAIL same_id_alloc_wins: got count=%0d valid=%0b want 0/0", freeCount_OUT, allocValid_OUT); end
  endtask

  task automatic test_simultaneous();
    freeReq_IN = 1'b1; freeId_IN = 6'd33;
    tick();
    freeId_IN = 6'd40;
    tick();
    freeReq_IN = 1'b0;
    tests++; if (allocId_OUT !== 6'd33 || freeCount_OUT !== 7'd2) begin fails++; $display("FAIL simul_setup: got id=%0d count=%0d want 33/2", allocId_OUT, freeCount_OUT); end
    allocReq_IN = 1'b1; freeReq_IN = 1'b1; freeId_IN = 6'd50;
    tick();
    freeReq_IN = 1'b0;
    tests++; if (allocId_OUT !== 6'd40 || freeCount_OUT !== 7'd2) begin fails++; $display("FAIL simul_alloc_free: got id=%0d count=%0d want 40/2", allocId_OUT, freeCount_OUT); end
    tick();
    allocReq_IN = 1'b0;
    tests++; if (allocId_OUT !== 6'd50 || freeCount_OUT !== 7'd1) begin fails++; $display("FAIL simul_bit50_set: got id=%0d count=%0d want 50/1", allocId_OUT, freeCount_OUT); end
  endtask

  task automatic test_freeze();
    FREEZE = 1'b1; allocReq_IN = 1'b1; freeReq_IN = 1'b1; freeId_IN = 6'd10; recover_IN = 1'b1;
    set_rat_offset(0);
    tick();
    tick();
    tests++; if (allocId_OUT !== 6'd50 || freeCount_OUT !== 7'd1 || busy_OUT !== 1'b0) begin fails++; $display("FAIL freeze_hold: got id=%0d count=%0d busy=%0b want 50/1/0", allocId_OUT, freeCount_OUT, busy_OUT); end
    FREEZE = 1'b0; allocReq_IN = 1'b0; freeReq_IN = 1'b0; recover_IN = 1'b0;
  endtask

  task automatic test_recover();
    set_rat_offset(32);
    recover_IN = 1'b1;
    tick();
    recover_IN = 1'b0;
    tests++; if (freeCount_OUT !== 7'd64) begin fails++; $display("FAIL recover_count_full: got %0d want 64", freeCount_OUT); end
    for (int c = 0; c < 32; c++) begin
      // Returning ID 40 after its entry has been processed must be ignored.
      freeReq_IN = (c >= 20 && c < 25); freeId_IN = 6'd40;
      tests++;
      if (busy_OUT !== 1'b1 || allocValid_OUT !== 1'b0) begin
        fails++;
        $display("FAIL rebuild_busy[%0d]: got busy=%0b valid=%0b want 1/0", c, busy_OUT, allocValid_OUT);
      end
      if (c == 15) begin
        FREEZE = 1'b1;
        tick();
        tick();
        FREEZE = 1'b0;
      end
      tick();
    end
    freeReq_IN = 1'b0;
    tests++; if (busy_OUT !== 1'b0 || allocValid_OUT !== 1'b1) begin fails++; $display("FAIL rebuild_done: got busy=%0b valid=%0b want 0/1", busy_OUT, allocValid_OUT); end
    tests++; if (allocId_OUT !== 6'd0) begin fails++; $display("FAIL rebuild_id: got %0d want 0", allocId_OUT); end
    tests++; if (freeCount_OUT !== 7'd32) begin fails++; $display("FAIL rebuild_count: got %0d want 32", freeCount_OUT); end
    allocReq_IN = 1'b1;
    tick();
    allocReq_IN = 1'b0;
    tests++; if (allocId_OUT !== 6'd1 || freeCount_OUT !== 7'd31) begin fails++; $display("FAIL post_rebuild_alloc: got id=%0d count=%0d want 1/31", allocId_OUT, freeCount_OUT); end
  endtask

  task automatic test_restart();
    set_rat_offset(32);
    recover_IN = 1'b1;
    tick();
    recover_IN = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    set_rat_offset(0);
    recover_IN = 1'b1;
    tick();
    recover_IN = 1'b0;
    tests++; if (freeCount_OUT !== 7'd64) begin fails++; $display("FAIL restart_count_full: got %0d want 64", freeCount_OUT); end
    for (int c = 0; c < 32; c++) begin
      tests++;
      if (busy_OUT !== 1'b1) begin fails++; $display("FAIL restart_busy[%0d]: got %0b want 1", c, busy_OUT); end
      tick();
    end
    tests++; if (busy_OUT !== 1'b0 || allocId_OUT !== 6'd32 || freeCount_OUT !== 7'd32) begin fails++; $display("FAIL restart_done: got busy=%0b id=%0d count=%0d want 0/32/32", busy_OUT, allocId_OUT, freeCount_OUT); end
  endtask

  task automatic test_duplicate();
    for (int i = 0; i < ARCH_REGS; i++) begin
      retRat_IN[(ARCH_REGS - 1 - i) * PHYS_WIDTH +: PHYS_WIDTH] = 6'd7;
    end
    recover_IN = 1'b1;
    tick();
    recover_IN = 1'b0;
    for (int c = 0; c < 32; c++) tick();
    tests++; if (busy_OUT !== 1'b0 || freeCount_OUT !== 7'd63 || allocId_OUT !== 6'd0) begin fails++; $display("FAIL duplicate_map: got busy=%0b count=%0d id=%0d want 0/63/0", busy_OUT, freeCount_OUT, allocId_OUT); end
  endtask

  task automatic test_reset_in_rebuild();
    set_rat_offset(32);
    recover_IN = 1'b1;
    tick();
    recover_IN = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    FREEZE = 1'b1; RESET = 1'b1;
    tick();
    FREEZE = 1'b0; RESET = 1'b0;
    tests++; if (busy_OUT !== 1'b0) begin fails++; $display("FAIL rst_rb_busy: got %0b want 0", busy_OUT); end
    tests++; if (freeCount_OUT !== 7'd32) begin fails++; $display("FAIL rst_rb_count: got %0d want 32", freeCount_OUT); end
    tests++; if (allocValid_OUT !== 1'b1 || allocId_OUT !== 6'd32) begin fails++; $display("FAIL rst_rb_alloc: got valid=%0b id=%0d want 1/32", allocValid_OUT, allocId_OUT); end
    for (int c = 0; c < 40; c++) tick();
    tests++; if (busy_OUT !== 1'b0 || freeCount_OUT !== 7'd32 || allocId_OUT !== 6'd32) begin fails++; $display("FAIL rst_rb_stable: got busy=%0b count=%0d id=%0d want 0/32/32", busy_OUT, freeCount_OUT, allocId_OUT); end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    RESET       = 1'b1;
    FREEZE      = 1'b0;
    allocReq_IN = 1'b0;
    freeReq_IN  = 1'b0;
    freeId_IN   = '0;
    recover_IN  = 1'b0;
    retRat_IN   = '0;
    test_reset();
    test_alloc_all();
    test_free_reuse();
    test_simultaneous();
    test_freeze();
    test_recover();
    test_restart();
    test_duplicate();
    test_reset_in_rebuild();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
